// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 32-bit memory between an instruction-fetch port
// (two-word fetch) and an RV32I load/store port, with starvation-bounded grant.
module mem_port_arbiter #(
  parameter int unsigned MEM_AW = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [63:0]       if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_inst_0,
  output logic [31:0]       if_resp_inst_1,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [63:0]       lsu_req_addr,
  input  logic              lsu_req_we,
  input  logic [31:0]       lsu_req_wdata,
  input  logic [2:0]        lsu_req_func3,
  output logic              lsu_resp_valid,
  output logic [31:0]       lsu_resp_data,
  output logic              lsu_resp_err,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, IF_LO, IF_HI, IF_CAP, IF_RESP, LSU_ACC, LSU_CAP, LSU_RESP
  } state_t;

  state_t            state;
  logic [1:0]        lsu_streak;
  logic              mem_en_q;
  logic [31:0]       inst0_q;
  logic [1:0]        ld_off_q;
  logic [2:0]        ld_f3_q;
  logic              st_q;

  logic              idle_c;
  logic              lsu_win_c;
  logic              if_win_c;
  logic [MEM_AW-1:0] if_word_c;
  logic [MEM_AW-1:0] lsu_word_c;
  logic              lsu_legal_c;
  logic              lsu_misal_c;
  logic              lsu_err_c;
  logic [3:0]        st_strb_c;
  logic [31:0]       st_data_c;
  logic [31:0]       ld_shift_c;
  logic [31:0]       ld_ext_c;
  logic              unused_c;

  // Grant: LSU has priority until it has won twice in a row against a waiting fetch.
  assign idle_c     = (state == IDLE) && !reset;
  assign lsu_win_c  = idle_c && lsu_req_valid && (!if_req_valid || (lsu_streak != 2'd2));
  assign if_win_c   = idle_c && if_req_valid && !lsu_win_c;
  assign if_req_ready  = if_win_c;
  assign lsu_req_ready = lsu_win_c;
  assign mem_en        = mem_en_q && !reset;

  assign if_word_c  = if_req_addr[MEM_AW+1:2];
  assign lsu_word_c = lsu_req_addr[MEM_AW+1:2];
  assign unused_c   = ^{if_req_addr[63:MEM_AW+2], if_req_addr[1:0], lsu_req_addr[63:MEM_AW+2]};

  // Request legality and store lane formatting
  always_comb begin
    lsu_legal_c = 1'b0;
    lsu_misal_c = 1'b0;
    st_strb_c   = 4'b1111;
    st_data_c   = lsu_req_wdata;
    if (lsu_req_we) lsu_legal_c = lsu_req_func3 inside {3'd0, 3'd1, 3'd2};
    else            lsu_legal_c = lsu_req_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    lsu_misal_c = ((lsu_req_func3[1:0] == 2'd1) && lsu_req_addr[0]) ||
                  ((lsu_req_func3[1:0] == 2'd2) && (lsu_req_addr[1:0] != 2'd0));
    case (lsu_req_func3[1:0])
      2'd0: begin
        st_strb_c = 4'b0001 << lsu_req_addr[1:0];
        st_data_c = {4{lsu_req_wdata[7:0]}};
      end
      2'd1: begin
        st_strb_c = 4'b0011 << lsu_req_addr[1:0];
        st_data_c = {2{lsu_req_wdata[15:0]}};
      end
      default: begin
        st_strb_c = 4'b1111;
        st_data_c = lsu_req_wdata;
      end
    endcase
  end

  assign lsu_err_c = !lsu_legal_c || lsu_misal_c;

  // Load data alignment and extension
  always_comb begin
    ld_shift_c = mem_rdata >> {ld_off_q, 3'b000};
    ld_ext_c   = mem_rdata;
    case (ld_f3_q)
      3'd0:    ld_ext_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      3'd1:    ld_ext_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'd4:    ld_ext_c = {24'd0, ld_shift_c[7:0]};
      3'd5:    ld_ext_c = {16'd0, ld_shift_c[15:0]};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      lsu_streak     <= 2'd0;
      mem_en_q       <= 1'b0;
      mem_addr       <= '0;
      mem_wstrb      <= 4'd0;
      mem_wdata      <= 32'd0;
      inst0_q        <= 32'd0;
      ld_off_q       <= 2'd0;
      ld_f3_q        <= 3'd0;
      st_q           <= 1'b0;
      if_resp_valid  <= 1'b0;
      if_resp_inst_0 <= 32'd0;
      if_resp_inst_1 <= 32'd0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= 32'd0;
      lsu_resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_win_c) begin
            state      <= IF_LO;
            lsu_streak <= 2'd0;
            mem_en_q   <= 1'b1;
            mem_addr   <= if_word_c;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
          end else if (lsu_win_c) begin
            if (if_req_valid && (lsu_streak != 2'd2)) lsu_streak <= lsu_streak + 2'd1;
            ld_off_q <= lsu_req_addr[1:0];
            ld_f3_q  <= lsu_req_func3;
            st_q     <= lsu_req_we;
            if (lsu_err_c) begin
              state          <= LSU_RESP;
              lsu_resp_valid <= 1'b1;
              lsu_resp_err   <= 1'b1;
              lsu_resp_data  <= 32'd0;
            end else begin
              state     <= LSU_ACC;
              mem_en_q  <= 1'b1;
              mem_addr  <= lsu_word_c;
              mem_wstrb <= lsu_req_we ? st_strb_c : 4'd0;
              mem_wdata <= lsu_req_we ? st_data_c : 32'd0;
            end
          end
        end
        IF_LO: begin
          state    <= IF_HI;
          mem_addr <= mem_addr + MEM_AW'(1);
        end
        IF_HI: begin
          state    <= IF_CAP;
          inst0_q  <= mem_rdata;
          mem_en_q <= 1'b0;
          mem_addr <= '0;
        end
        IF_CAP: begin
          state          <= IF_RESP;
          if_resp_valid  <= 1'b1;
          if_resp_inst_0 <= inst0_q;
          if_resp_inst_1 <= mem_rdata;
        end
        IF_RESP: begin
          state         <= IDLE;
          if_resp_valid <= 1'b0;
        end
        LSU_ACC: begin
          mem_en_q  <= 1'b0;
          mem_addr  <= '0;
          mem_wstrb <= 4'd0;
          mem_wdata <= 32'd0;
          if (st_q) begin
            state          <= LSU_RESP;
            lsu_resp_valid <= 1'b1;
            lsu_resp_data  <= 32'd0;
            lsu_resp_err   <= 1'b0;
          end else begin
            state <= LSU_CAP;
          end
        end
        LSU_CAP: begin
          state          <= LSU_RESP;
          lsu_resp_valid <= 1'b1;
          lsu_resp_data  <= ld_ext_c;
          lsu_resp_err   <= 1'b0;
        end
        LSU_RESP: begin
          state          <= IDLE;
          lsu_resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, the width of the memory word address.
REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
  clock  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  if_req_valid  in  1  fetch request.
  if_req_ready  out  1  fetch accept.
  if_req_addr  in  64  fetch byte address.
  if_resp_valid  out  1  fetch result pulse.
  if_resp_inst_0  out  32  word at the fetch address.
  if_resp_inst_1  out  32  word at the fetch address + 4.
  lsu_req_valid  in  1  load/store request.
  lsu_req_ready  out  1  LSU accept.
  lsu_req_addr  in  64  LSU byte address.
  lsu_req_we  in  1  1 = store.
  lsu_req_wdata  in  32  store data, right-aligned.
  lsu_req_func3  in  3  RV32I size/sign code.
  lsu_resp_valid  out  1  LSU result pulse.
  lsu_resp_data  out  32  extended load data (0 for a store or an error).
  lsu_resp_err  out  1  misaligned or illegal func3.
  mem_en  out  1  memory access strobe.
  mem_addr  out  MEM_AW  word address.
  mem_wstrb  out  4  byte write enables (0 = read).
  mem_wdata  out  32  lane-replicated write data.
  mem_rdata  in  32  read data, valid the cycle after a read strobe.

Function
REQ-003 SHALL share one single-ported 32-bit memory between fetch and LSU; SHALL have at most one access per cycle.
REQ-004 SHALL have states IDLE, IF_LO, IF_HI, IF_CAP, IF_RESP, LSU_ACC, LSU_CAP, LSU_RESP.
REQ-005 SHALL drive ready outputs only in IDLE, and then combinationally from the grant decision; a request is accepted when valid && ready.
REQ-006 Grant rule when both requests are valid in IDLE: LSU wins unless lsu_streak == 2, in which case fetch wins. If only one request is valid, that request wins.
REQ-007 lsu_streak (2-bit) SHALL increment, saturating at 2, on an LSU grant while if_req_valid = 1, and SHALL clear on a fetch grant.
REQ-008 Word address = addr[MEM_AW+1:2]; fetch SHALL ignore addr[1:0].
REQ-009 Fetch accepted at cycle T: at T+1 (IF_LO), mem_en = 1, mem_addr = W, wstrb = 0.
REQ-010 Fetch, continued: at T+2 (IF_HI), mem_en = 1, mem_addr = W+1 modulo 2^MEM_AW, and rdata is captured as inst_0.
REQ-011 Fetch, continued: at T+3 (IF_CAP), rdata is captured as inst_1.
REQ-012 Fetch, continued: at T+4 (IF_RESP), if_resp_valid = 1 for exactly one cycle; the FSM returns to IDLE at T+5.
REQ-013 LSU legality: loads with func3 in {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU}; stores with func3 in {0 SB, 1 SH, 2 SW}.
REQ-014 An LSU request SHALL be an error when func3 is illegal, when halfword addr[0] = 1, or when word addr[1:0] != 0.
REQ-015 Error request accepted at T: no mem_en. At T+1 (LSU_RESP), resp_valid = 1, err = 1, data = 0.
REQ-016 Store accepted at T: at T+1 (LSU_ACC), mem_en = 1.
REQ-017 Store wstrb: SB = 0001 << addr[1:0]; SH = 0011 << addr[1:0]; SW = 1111.
REQ-018 Store wdata: SB replicates wdata[7:0] in all four lanes; SH replicates wdata[15:0] in both halves.
REQ-019 Store response: at T+2, resp_valid = 1, data = 0, err = 0.
REQ-020 Load accepted at T: at T+1 (LSU_ACC), mem_en = 1, wstrb = 0.
REQ-021 Load, continued: at T+2 (LSU_CAP), rdata is captured.
REQ-022 Load, continued: at T+3 (LSU_RESP), resp_valid = 1 with data extracted at byte offset addr[1:0].
REQ-023 Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 After any RESP state the FSM SHALL return to IDLE the following cycle; no new request is accepted in a RESP cycle.
REQ-025 All request fields SHALL be registered at accept; input changes after accept have no effect.
REQ-026 Response data outputs SHALL hold their last value when their valid is low.
REQ-027 mem_en, mem_wstrb, mem_addr and mem_wdata SHALL be 0 in every state that does not access memory.

Reset
REQ-028 While reset = 1 at a clock edge: state = IDLE, lsu_streak = 0, all registered outputs = 0.
REQ-029 While reset = 1, both ready outputs and mem_en SHALL be forced to 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no response pulse; the aborted request is not retried.

Verification
REQ-031 Fetch only: mem word 0x10 = 0x00000013, word 0x11 = 0x00100093; fetch addr 0x40 at T -> mem_addr 0x10 at T+1, 0x11 at T+2; at T+4 if_resp_valid = 1, inst_0 = 0x00000013, inst_1 = 0x00100093.
REQ-032 Byte store then signed load: SB addr 0x103, wdata 0xA5 -> wstrb 1000, mem_wdata 0xA5A5A5A5; then LB addr 0x103 -> data 0xFFFFFFA5; LBU -> data 0x000000A5.
REQ-033 Misaligned access: LW at addr 0x102 -> no mem_en, resp_valid at T+1 with err = 1, data = 0; LSU func3 = 3 -> same response.
REQ-034 Contention: both requesters valid continuously -> grant order LSU, LSU, fetch, LSU, LSU, fetch; no overlapping mem_en.
REQ-035 Wrap-around: fetch addr 0x3FFFC with MEM_AW = 16 -> mem_addr 0xFFFF then 0x0000.
REQ-036 Reset during IF_HI -> no if_resp_valid; next cycle ready outputs reflect the request valids in IDLE; all outputs read 0.
